comparator_4bit: RTL and testbench

COMPARATOR_4BIT -- requirements
Module: comparator_4bit

---
 rtl/comparator_pkg.sv | 24 ++
 rtl/comparator_1bit.sv | 21 ++
 rtl/comparator_4bit.sv | 74 +++++++
 tb/tb_comparator_4bit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared width, result encoding and flag encoder for the 4-bit comparator
package comparator_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    LT   = 2'd1,
    EQ   = 2'd2,
    GT   = 2'd3
  } result_e;

  // Collapse the cascade's three flags into one encoded result; the cascade
  // guarantees at most one flag is high, so priority order is irrelevant.
  function automatic result_e encode_result(input logic f_lt, input logic f_eq, input logic f_gt);
    result_e res;
    res = NONE;
    if (f_lt)      res = LT;
    else if (f_gt) res = GT;
    else if (f_eq) res = EQ;
    return res;
  endfunction

endpackage

// File: rtl/comparator_1bit.sv
// rtl/comparator_1bit.sv - one MSB-first cascade slice of the magnitude comparator
module comparator_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic lt_in,
  input  logic eq_in,
  input  logic gt_in,
  output logic lt_out,
  output logic eq_out,
  output logic gt_out
);

  // A decision already made by a more significant bit passes straight
  // through; only while the upper bits are still equal does this bit decide.
  always_comb begin
    lt_out = lt_in | (eq_in & ~a_i &  b_i);
    gt_out = gt_in | (eq_in &  a_i & ~b_i);
    eq_out = eq_in & ~(a_i ^ b_i);
  end

endmodule

// File: rtl/comparator_4bit.sv
// rtl/comparator_4bit.sv - registered signed/unsigned 4-bit comparator with one-cycle latency
module comparator_4bit
  import comparator_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic             out_valid
);

  // In two's complement a set MSB means "smaller", so flipping both MSBs
  // turns the signed compare into an unsigned one; equality is unaffected.
  logic w_a3;
  logic w_b3;
  assign w_a3 = a[3] ^ signed_mode;
  assign w_b3 = b[3] ^ signed_mode;

  logic w_lt3, w_eq3, w_gt3;
  logic w_lt2, w_eq2, w_gt2;
  logic w_lt1, w_eq1, w_gt1;
  logic w_lt0, w_eq0, w_gt0;

  comparator_1bit u_bit3 (
    .a_i    (w_a3),  .b_i    (w_b3),
    .lt_in  (1'b0),  .eq_in  (1'b1),  .gt_in  (1'b0),
    .lt_out (w_lt3), .eq_out (w_eq3), .gt_out (w_gt3)
  );

  comparator_1bit u_bit2 (
    .a_i    (a[2]),  .b_i    (b[2]),
    .lt_in  (w_lt3), .eq_in  (w_eq3), .gt_in  (w_gt3),
    .lt_out (w_lt2), .eq_out (w_eq2), .gt_out (w_gt2)
  );

  comparator_1bit u_bit1 (
    .a_i    (a[1]),  .b_i    (b[1]),
    .lt_in  (w_lt2), .eq_in  (w_eq2), .gt_in  (w_gt2),
    .lt_out (w_lt1), .eq_out (w_eq1), .gt_out (w_gt1)
  );

  comparator_1bit u_bit0 (
    .a_i    (a[0]),  .b_i    (b[0]),
    .lt_in  (w_lt1), .eq_in  (w_eq1), .gt_in  (w_gt1),
    .lt_out (w_lt0), .eq_out (w_eq0), .gt_out (w_gt0)
  );

  result_e r_result;
  logic    r_out_valid;

  // Capture the cascade result on accepted inputs; hold it otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result    <= NONE;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result <= encode_result(w_lt0, w_eq0, w_gt0);
      end
    end
  end

  assign lt        = (r_result == LT);
  assign eq        = (r_result == EQ);
  assign gt        = (r_result == GT);
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_comparator_4bit.sv
// tb/tb_comparator_4bit.sv - directed and random scoreboard bench for comparator_4bit
module tb_comparator_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       signed_mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       lt, eq, gt, out_valid;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] sb[$];
  logic [2:0] m_flags = 3'b000;
  logic       m_ov = 1'b0;

  comparator_4bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .lt          (lt),
    .eq          (eq),
    .gt          (gt),
    .signed_mode (signed_mode),
    .in_valid    (in_valid),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_cmp(input logic [3:0] av, input logic [3:0] bv, input logic sm);
    int x;
    int y;
    x = int'(av);
    y = int'(bv);
    if (sm && av[3]) x = x - 16;
    if (sm && bv[3]) y = y - 16;
    if (x < y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  task automatic apply(input string tag, input logic rn, input logic iv, input logic sm,
                       input logic [3:0] av, input logic [3:0] bv);
    logic [3:0] exp_v;
    logic [3:0] obs_v;
    rst_n       = rn;
    in_valid    = iv;
    signed_mode = sm;
    a           = av;
    b           = bv;
    if (!rn) begin
      m_flags = 3'b000;
      m_ov    = 1'b0;
    end else if (iv) begin
      m_flags = ref_cmp(av, bv, sm);
      m_ov    = 1'b1;
    end else begin
      m_ov    = 1'b0;
    end
    sb.push_back({m_flags, m_ov});
    @(posedge clk);
    #1;
    vectors++;
    obs_v = {lt, eq, gt, out_valid};
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed lt/eq/gt/ov=%b", tag, obs_v);
    end else begin
      exp_v = sb.pop_front();
      assert (obs_v === exp_v)
      else begin
        miscompares++;
        $error("FAIL %s: lt/eq/gt/ov observed %b expected %b", tag, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    #1;
    // reset state, including an input presented during reset
    apply("reset_idle",     1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    apply("reset_discard",  1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000);
    apply("first_after_rst",1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000);
    // basic unsigned
    apply("u_lt_1_2",       1'b1, 1'b1, 1'b0, 4'b0001, 4'b0010);
    // MSB behaviour in both modes
    apply("u_gt_10_3",      1'b1, 1'b1, 1'b0, 4'b1010, 4'b0011);
    apply("s_lt_m6_3",      1'b1, 1'b1, 1'b1, 4'b1010, 4'b0011);
    // equality in both modes
    apply("u_eq_6",         1'b1, 1'b1, 1'b0, 4'b0110, 4'b0110);
    apply("s_eq_6",         1'b1, 1'b1, 1'b1, 4'b0110, 4'b0110);
    apply("u_eq_0",         1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    apply("s_eq_0",         1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
    // 15>14 and -1>-2
    apply("u_gt_15_14",     1'b1, 1'b1, 1'b0, 4'b1111, 4'b1110);
    apply("s_gt_m1_m2",     1'b1, 1'b1, 1'b1, 4'b1111, 4'b1110);
    // extremes: -8 vs 7
    apply("s_lt_m8_7",      1'b1, 1'b1, 1'b1, 4'b1000, 4'b0111);
    apply("u_gt_8_7",       1'b1, 1'b1, 1'b0, 4'b1000, 4'b0111);
    // hold while in_valid low
    apply("hold_accept",    1'b1, 1'b1, 1'b0, 4'b0001, 4'b0010);
    apply("hold_idle1",     1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000);
    apply("hold_idle2",     1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111);
    // reset clears a held result
    apply("reset_mid",      1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000);
    apply("post_reset_gt",  1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000);
    // back-to-back and mixed random traffic
    for (int i = 0; i < 60; i++) begin
      apply("random",
            ($urandom_range(0, 19) != 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
